// File: rtl/lift_ctrl_nfloor_if.sv
// Hall-call and car-status bundle for the N-floor lift controller.
// The controller side uses the slave modport; whoever issues calls and
// watches the car uses the master modport.
interface lift_ctrl_nfloor_if #(
  parameter int FLOORS  = 4,
  parameter int FLOOR_W = 2
);
  // Hall-call strobe (sampled every cycle by the controller)
  logic               call_vld;
  logic [FLOOR_W-1:0] call_floor;
  logic               call_dir;    // 0 = up, 1 = down

  // Car status
  logic [1:0]         dout;        // UP=00, DOWN=01, STAY=10
  logic [FLOOR_W-1:0] cur_floor;
  logic               door_open;
  logic [FLOORS-1:0]  up_pending;
  logic [FLOORS-1:0]  dn_pending;
  logic               busy;

  modport master (
    output call_vld, call_floor, call_dir,
    input  dout, cur_floor, door_open, up_pending, dn_pending, busy
  );

  modport slave (
    input  call_vld, call_floor, call_dir,
    output dout, cur_floor, door_open, up_pending, dn_pending, busy
  );
endinterface

// File: rtl/lift_ctrl_nfloor.sv
// N-floor collective (SCAN) elevator controller.
// Hall calls are latched into per-floor up/down pending registers; the car
// sweeps in one direction serving calls, times each floor with a travel
// counter and holds the door with a dwell counter. The interface instance
// bound to "bus" must use the same FLOORS/FLOOR_W as this module.
module lift_ctrl_nfloor #(
  parameter int FLOORS     = 4,
  parameter int FLOOR_W    = 2,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input logic                clk,
  input logic                rst,
  lift_ctrl_nfloor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DOOR    = 2'd3
  } state_t;

  localparam logic [1:0] DOUT_UP   = 2'b00;
  localparam logic [1:0] DOUT_DN   = 2'b01;
  localparam logic [1:0] DOUT_STAY = 2'b10;

  // Counters are sized to hold TRAVEL_CYC-1 / DOOR_CYC-1, minimum one bit
  localparam int TCW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DCW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYC - 1);
  localparam logic [DCW-1:0] DOOR_LAST   = DCW'(DOOR_CYC - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W-1:0] BOT_FLOOR = '0;

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
  logic               dir_up_q, dir_up_d;
  logic [FLOORS-1:0]  up_pend_q, up_pend_d;
  logic [FLOORS-1:0]  dn_pend_q, dn_pend_d;
  logic [TCW-1:0]     travel_cnt_q, travel_cnt_d;
  logic [DCW-1:0]     dwell_cnt_q, dwell_cnt_d;
  // Which call directions at the open floor are swallowed by the dwell
  logic               abs_up_q, abs_up_d;
  logic               abs_dn_q, abs_dn_d;

  // Floor-relative masks for the current floor and the floor being reached
  logic [FLOOR_W-1:0] nxt_up, nxt_dn;
  logic [FLOORS-1:0]  at_cur, above_cur, below_cur;
  logic [FLOORS-1:0]  at_nup, above_nup;
  logic [FLOORS-1:0]  at_ndn, below_ndn;
  logic [FLOORS-1:0]  set_up, set_dn;
  logic [FLOORS-1:0]  clr_up, clr_dn;
  logic [FLOORS-1:0]  pend_all;

  logic any_here, any_above, any_below;
  logic any_above_nup, any_below_ndn;
  logic stop_up, stop_dn;
  logic absorb_hit;
  logic take_dec;

  state_t dec_state;
  logic   dec_dir_up;

  assign nxt_up   = cur_floor_q + FLOOR_W'(1);
  assign nxt_dn   = cur_floor_q - FLOOR_W'(1);
  assign pend_all = up_pend_q | dn_pend_q;

  // A call at the open floor in a served direction only restarts the dwell
  assign absorb_hit = (state_q == DOOR) && bus.call_vld &&
                      (bus.call_floor == cur_floor_q) &&
                      (bus.call_dir ? abs_dn_q : abs_up_q);

  genvar gi;
  generate
    for (gi = 0; gi < FLOORS; gi++) begin : g_floor
      localparam logic [FLOOR_W-1:0] FIDX = FLOOR_W'(gi);
      // No up-call from the top floor, no down-call from the bottom floor
      localparam bit CAN_UP = (gi < FLOORS - 1);
      localparam bit CAN_DN = (gi > 0);

      logic call_here;
      assign call_here = bus.call_vld && (bus.call_floor == FIDX) && !absorb_hit;

      assign at_cur[gi]    = (FIDX == cur_floor_q);
      assign above_cur[gi] = (FIDX >  cur_floor_q);
      assign below_cur[gi] = (FIDX <  cur_floor_q);
      assign at_nup[gi]    = (FIDX == nxt_up);
      assign above_nup[gi] = (FIDX >  nxt_up);
      assign at_ndn[gi]    = (FIDX == nxt_dn);
      assign below_ndn[gi] = (FIDX <  nxt_dn);

      assign set_up[gi] = CAN_UP && call_here && !bus.call_dir;
      assign set_dn[gi] = CAN_DN && call_here &&  bus.call_dir;
    end
  endgenerate

  assign any_here      = |(pend_all & at_cur);
  assign any_above     = |(pend_all & above_cur);
  assign any_below     = |(pend_all & below_cur);
  assign any_above_nup = |(pend_all & above_nup);
  assign any_below_ndn = |(pend_all & below_ndn);

  // Stop at the reached floor for a same-direction call, for the last call
  // of the sweep, or unconditionally at the end of the shaft
  assign stop_up = (|(up_pend_q & at_nup)) ||
                   (!any_above_nup && (|(pend_all & at_nup))) ||
                   (nxt_up == TOP_FLOOR);
  assign stop_dn = (|(dn_pend_q & at_ndn)) ||
                   (!any_below_ndn && (|(pend_all & at_ndn))) ||
                   (nxt_dn == BOT_FLOOR);

  // Clears from door entry take priority over a same-cycle call
  assign up_pend_d = (up_pend_q | set_up) & ~clr_up;
  assign dn_pend_d = (dn_pend_q | set_dn) & ~clr_dn;

  // Idle-style decision shared by IDLE and door-dwell expiry
  always_comb begin
    dec_state  = IDLE;
    dec_dir_up = dir_up_q;
    if (any_here) begin
      dec_state = DOOR;
    end else if (any_above && any_below) begin
      dec_state = dir_up_q ? MOVE_UP : MOVE_DN;
    end else if (any_above) begin
      dec_state  = MOVE_UP;
      dec_dir_up = 1'b1;
    end else if (any_below) begin
      dec_state  = MOVE_DN;
      dec_dir_up = 1'b0;
    end
  end

  // Next-state logic: travel timing, arrival stop/clear, dwell handling
  always_comb begin
    state_d      = state_q;
    cur_floor_d  = cur_floor_q;
    dir_up_d     = dir_up_q;
    travel_cnt_d = travel_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    abs_up_d     = abs_up_q;
    abs_dn_d     = abs_dn_q;
    clr_up       = '0;
    clr_dn       = '0;
    take_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        take_dec = 1'b1;
      end

      MOVE_UP: begin
        if (travel_cnt_q == TRAVEL_LAST) begin
          travel_cnt_d = '0;
          cur_floor_d  = nxt_up;
          if (stop_up) begin
            state_d     = DOOR;
            dwell_cnt_d = '0;
            clr_up      = at_nup;
            abs_up_d    = 1'b1;
            abs_dn_d    = 1'b0;
            // End of the upward sweep: serve the down-call here too and turn
            if (!any_above_nup) begin
              clr_dn   = at_nup;
              abs_dn_d = 1'b1;
              dir_up_d = 1'b0;
            end
          end
        end else begin
          travel_cnt_d = travel_cnt_q + TCW'(1);
        end
      end

      MOVE_DN: begin
        if (travel_cnt_q == TRAVEL_LAST) begin
          travel_cnt_d = '0;
          cur_floor_d  = nxt_dn;
          if (stop_dn) begin
            state_d     = DOOR;
            dwell_cnt_d = '0;
            clr_dn      = at_ndn;
            abs_dn_d    = 1'b1;
            abs_up_d    = 1'b0;
            // End of the downward sweep: serve the up-call here too and turn
            if (!any_below_ndn) begin
              clr_up   = at_ndn;
              abs_up_d = 1'b1;
              dir_up_d = 1'b1;
            end
          end
        end else begin
          travel_cnt_d = travel_cnt_q + TCW'(1);
        end
      end

      DOOR: begin
        if (absorb_hit) begin
          dwell_cnt_d = '0;
        end else if (dwell_cnt_q == DOOR_LAST) begin
          take_dec = 1'b1;
        end else begin
          dwell_cnt_d = dwell_cnt_q + DCW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_dec) begin
      state_d      = dec_state;
      dir_up_d     = dec_dir_up;
      travel_cnt_d = '0;
      dwell_cnt_d  = '0;
      if (dec_state == DOOR) begin
        clr_up   = at_cur;
        clr_dn   = at_cur;
        abs_up_d = 1'b1;
        abs_dn_d = 1'b1;
      end
    end
  end

  // State and datapath registers with immediate reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_floor_q  <= '0;
      dir_up_q     <= 1'b1;
      up_pend_q    <= '0;
      dn_pend_q    <= '0;
      travel_cnt_q <= '0;
      dwell_cnt_q  <= '0;
      abs_up_q     <= 1'b0;
      abs_dn_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_floor_q  <= cur_floor_d;
      dir_up_q     <= dir_up_d;
      up_pend_q    <= up_pend_d;
      dn_pend_q    <= dn_pend_d;
      travel_cnt_q <= travel_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      abs_up_q     <= abs_up_d;
      abs_dn_q     <= abs_dn_d;
    end
  end

  // Drive direction code and door status from the current state
  always_comb begin
    bus.dout      = DOUT_STAY;
    bus.door_open = 1'b0;
    case (state_q)
      MOVE_UP: bus.dout = DOUT_UP;
      MOVE_DN: bus.dout = DOUT_DN;
      DOOR:    bus.door_open = 1'b1;
      default: bus.dout = DOUT_STAY;
    endcase
  end

  assign bus.cur_floor  = cur_floor_q;
  assign bus.up_pending = up_pend_q;
  assign bus.dn_pending = dn_pend_q;
  assign bus.busy       = (state_q != IDLE) || (|up_pend_q) || (|dn_pend_q);

endmodule

// File: tb/tb_lift_ctrl_nfloor.sv
// Directed bench for lift_ctrl_nfloor: three instances (4, 3 and 8 floors)
// share one call driver; "sel" routes the strobe and the status readers.
module tb_lift_ctrl_nfloor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       call_vld;
  logic [2:0] call_floor;
  logic       call_dir;
  int         sel;
  int         check_cnt = 0;
  int         err_cnt   = 0;
  int         n;

  always #5 clk = ~clk;

  lift_ctrl_nfloor_if #(.FLOORS(4), .FLOOR_W(2)) if4 ();
  lift_ctrl_nfloor_if #(.FLOORS(3), .FLOOR_W(2)) if3 ();
  lift_ctrl_nfloor_if #(.FLOORS(8), .FLOOR_W(3)) if8 ();

  assign if4.call_vld   = call_vld && (sel == 0);
  assign if4.call_floor = call_floor[1:0];
  assign if4.call_dir   = call_dir;
  assign if3.call_vld   = call_vld && (sel == 1);
  assign if3.call_floor = call_floor[1:0];
  assign if3.call_dir   = call_dir;
  assign if8.call_vld   = call_vld && (sel == 2);
  assign if8.call_floor = call_floor;
  assign if8.call_dir   = call_dir;

  lift_ctrl_nfloor #(.FLOORS(4), .FLOOR_W(2), .TRAVEL_CYC(4), .DOOR_CYC(3)) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave));
  lift_ctrl_nfloor #(.FLOORS(3), .FLOOR_W(2), .TRAVEL_CYC(4), .DOOR_CYC(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave));
  lift_ctrl_nfloor #(.FLOORS(8), .FLOOR_W(3), .TRAVEL_CYC(4), .DOOR_CYC(3)) u_dut8 (
    .clk(clk), .rst(rst), .bus(if8.slave));

  function automatic logic [7:0] g_door();
    case (sel)
      0: return 8'(if4.door_open);
      1: return 8'(if3.door_open);
      default: return 8'(if8.door_open);
    endcase
  endfunction

  function automatic logic [7:0] g_dout();
    case (sel)
      0: return 8'(if4.dout);
      1: return 8'(if3.dout);
      default: return 8'(if8.dout);
    endcase
  endfunction

  function automatic logic [7:0] g_floor();
    case (sel)
      0: return 8'(if4.cur_floor);
      1: return 8'(if3.cur_floor);
      default: return 8'(if8.cur_floor);
    endcase
  endfunction

  function automatic logic [7:0] g_up();
    case (sel)
      0: return 8'(if4.up_pending);
      1: return 8'(if3.up_pending);
      default: return 8'(if8.up_pending);
    endcase
  endfunction

  function automatic logic [7:0] g_dn();
    case (sel)
      0: return 8'(if4.dn_pending);
      1: return 8'(if3.dn_pending);
      default: return 8'(if8.dn_pending);
    endcase
  endfunction

  function automatic logic [7:0] g_busy();
    case (sel)
      0: return 8'(if4.busy);
      1: return 8'(if3.busy);
      default: return 8'(if8.busy);
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hall_call(input int f, input logic d);
    call_floor = 3'(f);
    call_dir   = d;
    call_vld   = 1'b1;
    $display("[%0t] dut%0d call floor=%0d dir=%s", $time, sel, f, d ? "down" : "up");
    step();
    call_vld = 1'b0;
  endtask

  // Step until door_open equals val (bounded); n returns the cycles taken
  task automatic wait_door(input logic val, input int max, output int cyc);
    cyc = 0;
    while ((g_door() != 8'(val)) && (cyc < max)) begin
      step();
      cyc++;
    end
    check_val("wait_door", g_door(), 32'(val));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    sel = 0; call_vld = 1'b0; call_floor = '0; call_dir = 1'b0; rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check_val("rst_dout",  g_dout(),  2);
    check_val("rst_floor", g_floor(), 0);
    check_val("rst_door",  g_door(),  0);
    check_val("rst_up",    g_up(),    0);
    check_val("rst_dn",    g_dn(),    0);
    check_val("rst_busy",  g_busy(),  0);

    // Call at the current floor: one cycle pending, then 3 cycles of door
    hall_call(0, 1'b0);
    check_val("here_up_set", g_up(),   1);
    check_val("here_door0",  g_door(), 0);
    step();
    check_val("here_door1",  g_door(), 1);
    check_val("here_up_clr", g_up(),   0);
    check_val("here_dout1",  g_dout(), 2);
    step();
    check_val("here_door2",  g_door(), 1);
    step();
    check_val("here_door3",  g_door(), 1);
    check_val("here_dout3",  g_dout(), 2);
    step();
    check_val("here_closed", g_door(), 0);
    check_val("here_busy",   g_busy(), 0);

    // Single trip 0 -> 2 for a down-call at 2
    hall_call(2, 1'b1);
    check_val("trip_dn_set", g_dn(),   4);
    check_val("trip_idle",   g_dout(), 2);
    for (int i = 0; i < 8; i++) begin
      step();
      check_val("trip_dout_up", g_dout(),  0);
      check_val("trip_floor",   g_floor(), i / 4);
    end
    step();
    check_val("trip_arrive_floor", g_floor(), 2);
    check_val("trip_arrive_door",  g_door(),  1);
    check_val("trip_dn_clr",       g_dn(),    0);
    check_val("trip_arrive_dout",  g_dout(),  2);
    step();
    check_val("trip_door2", g_door(), 1);
    step();
    check_val("trip_door3", g_door(), 1);
    step();
    check_val("trip_closed", g_door(), 0);
    check_val("trip_busy",   g_busy(), 0);

    // Dropped calls
    hall_call(3, 1'b0);
    check_val("inv_top_up",  g_up(),   0);
    check_val("inv_top_bsy", g_busy(), 0);
    hall_call(0, 1'b1);
    check_val("inv_bot_dn",  g_dn(),   0);
    check_val("inv_bot_bsy", g_busy(), 0);
    sel = 1;
    hall_call(3, 1'b0);
    check_val("inv3_range_up", g_up(),   0);
    check_val("inv3_range_dn", g_dn(),   0);
    check_val("inv3_range_bs", g_busy(), 0);
    hall_call(2, 1'b0);
    check_val("inv3_top_up",   g_up(),   0);
    sel = 0;

    // Asynchronous reset while moving up from floor 2
    hall_call(3, 1'b1);
    check_val("ar_dn_set", g_dn(), 8);
    step();
    check_val("ar_dout_up", g_dout(), 0);
    step();
    check_val("ar_dout_up2", g_dout(), 0);
    #2;
    rst = 1'b1;
    #1;
    check_val("ar_dout",  g_dout(),  2);
    check_val("ar_floor", g_floor(), 0);
    check_val("ar_door",  g_door(),  0);
    check_val("ar_dn",    g_dn(),    0);
    check_val("ar_busy",  g_busy(),  0);
    step();
    step();
    rst = 1'b0;
    step();

    // Collective sweep: 3-down, 1-up, 2-down from floor 0
    hall_call(3, 1'b1);
    hall_call(1, 1'b0);
    hall_call(2, 1'b1);
    check_val("col_up_set", g_up(), 2);
    check_val("col_dn_set", g_dn(), 12);
    wait_door(1'b1, 40, n);
    check_val("col_t1",      n,         3);
    check_val("col_f1",      g_floor(), 1);
    check_val("col_f1_up",   g_up(),    0);
    check_val("col_f1_dn",   g_dn(),    12);
    wait_door(1'b0, 40, n);
    check_val("col_dwell1",  n,         3);
    check_val("col_go_up",   g_dout(),  0);
    wait_door(1'b1, 40, n);
    check_val("col_t3",      n,         8);
    check_val("col_f3",      g_floor(), 3);
    check_val("col_f3_dn",   g_dn(),    4);
    check_val("col_f3_up",   g_up(),    0);
    wait_door(1'b0, 40, n);
    check_val("col_dwell3",  n,         3);
    check_val("col_go_dn",   g_dout(),  1);
    wait_door(1'b1, 40, n);
    check_val("col_t2",      n,         4);
    check_val("col_f2",      g_floor(), 2);
    check_val("col_f2_dn",   g_dn(),    0);
    wait_door(1'b0, 40, n);
    check_val("col_dwell2",  n,         3);
    check_val("col_idle",    g_dout(),  2);
    check_val("col_busy",    g_busy(),  0);

    // Same-cycle set and door-entry clear at floor 2: clear wins
    hall_call(2, 1'b0);
    check_val("coll_up_set", g_up(), 4);
    hall_call(2, 1'b1);
    check_val("coll_door",   g_door(), 1);
    check_val("coll_dn",     g_dn(),   0);
    check_val("coll_up",     g_up(),   0);
    wait_door(1'b0, 40, n);
    check_val("coll_dwell",  n,        3);
    check_val("coll_busy",   g_busy(), 0);

    // Eight floors: absorb a 5-up during the dwell at 5 while heading up
    sel = 2;
    hall_call(5, 1'b0);
    hall_call(7, 1'b1);
    check_val("abs_up_set", g_up(), 8'h20);
    check_val("abs_dn_set", g_dn(), 8'h80);
    wait_door(1'b1, 60, n);
    check_val("abs_t5",     n,         20);
    check_val("abs_f5",     g_floor(), 5);
    check_val("abs_f5_up",  g_up(),    0);
    check_val("abs_f5_dn",  g_dn(),    8'h80);
    step();
    check_val("abs_dwell2", g_door(),  1);
    hall_call(5, 1'b0);
    check_val("abs_door",   g_door(),  1);
    check_val("abs_up_not", g_up(),    0);
    wait_door(1'b0, 40, n);
    check_val("abs_rest",   n,         3);
    check_val("abs_go_up",  g_dout(),  0);
    wait_door(1'b1, 40, n);
    check_val("abs_t7",     n,         8);
    check_val("abs_f7",     g_floor(), 7);
    check_val("abs_f7_dn",  g_dn(),    0);
    wait_door(1'b0, 40, n);
    check_val("abs_dwell7", n,         3);
    check_val("abs_busy",   g_busy(),  0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lift_ctrl_nfloor.md
Name: lift_ctrl_nfloor

Overview:
- Parametrised N-floor elevator controller; successor to the fixed 4-floor buffered lift FSM.
- Latches hall calls (up/down per floor) into pending-request registers.
- Runs a collective (SCAN) policy with per-floor travel timing and a door-dwell timer.
- Drives the same UP/DOWN/STAY direction code to the car drive, plus floor and door status.

Parameters:
FLOORS, 4, number of floors (2..16); floor 0 is the bottom floor.
FLOOR_W, 2, floor index width; must be >= clog2(FLOORS).
TRAVEL_CYC, 4, clock cycles to move one floor (>=1).
DOOR_CYC, 3, clock cycles the door stays open (>=1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
call_vld  input  1  hall-call strobe; sampled every cycle.
call_floor  input  FLOOR_W  floor of the call.
call_dir  input  1  call direction: 0 = up, 1 = down.
dout  output  2  car direction: UP=2'b00, DOWN=2'b01, STAY=2'b10.
cur_floor  output  FLOOR_W  current car floor.
door_open  output  1  door open at cur_floor.
up_pending  output  FLOORS  latched up-calls, one bit per floor.
dn_pending  output  FLOORS  latched down-calls, one bit per floor.
busy  output  1  high when the FSM is not IDLE or any pending bit is set.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-move or mid-door):
  - state=IDLE, cur_floor=0, dir_up=1.
  - up_pending=0, dn_pending=0, travel and dwell counters=0.
  - Outputs: dout=STAY, door_open=0, busy=0.
- Call latch:
  - When call_vld=1, the matching pending bit is set at the next edge.
  - Dropped calls (no effect): call_floor>=FLOORS; up-call at floor FLOORS-1; down-call at floor 0.
  - A call that is already pending has no further effect.
- FSM states: IDLE, MOVE_UP, MOVE_DN, DOOR.
- dout: UP in MOVE_UP, DOWN in MOVE_DN, STAY in IDLE and DOOR. door_open=1 only in DOOR.
- IDLE, evaluated every cycle on registered pending bits (so a call strobed in cycle t moves the car at edge t+2):
  - Any pending bit at cur_floor -> DOOR; clear both bits at that floor.
  - Else if calls are pending both above and below: go MOVE_UP if dir_up=1, else MOVE_DN.
  - Else if calls only above -> MOVE_UP, dir_up=1.
  - Else if calls only below -> MOVE_DN, dir_up=0.
- MOVE_UP:
  - Travel counter runs 0..TRAVEL_CYC-1; on terminal count cur_floor increments and the counter resets.
  - At the new floor, stop (-> DOOR) if up_pending is set there, or if no call is pending above it and any call is pending there.
  - Otherwise continue moving.
  - Cannot pass floor FLOORS-1: the stop condition is guaranteed there.
- MOVE_DN: mirror of MOVE_UP, using dn_pending and decrementing cur_floor.
- DOOR entry clears:
  - Arriving up: clear up_pending[cur_floor]. If nothing is pending above, also clear dn_pending[cur_floor] and set dir_up=0.
  - Arriving down: mirror rule (may set dir_up=1).
- DOOR dwell:
  - Lasts DOOR_CYC cycles.
  - A call at cur_floor in the current service direction (or either direction if both were cleared on entry) is absorbed: not latched, dwell counter restarts.
  - On dwell expiry, apply the IDLE decision rules, excluding re-opening for absorbed calls. If nothing is pending -> IDLE.
- Set/clear collision: if a call set and a DOOR-entry clear target the same bit in the same cycle, the clear wins.
- All arithmetic is unsigned FLOOR_W bits. The "above/below pending" tests are reductions over pending bits masked by cur_floor.

Test Plan:
- Reset: hold rst=1 then release -> dout=STAY, cur_floor=0, door_open=0, pending=0, busy=0. Assert rst while dout=UP -> all outputs return to reset values immediately, with no clock edge.
- Call at current floor: car idle at 0, strobe 0-up -> up_pending[0] is set for 1 cycle, then door_open=1 for exactly 3 cycles; dout stays STAY throughout; returns to IDLE.
- Single trip: at floor 0, strobe 2-down -> dout=UP for 8 cycles, cur_floor goes 0->1->2; door_open for 3 cycles; dn_pending[2] cleared; then STAY, busy=0.
- Invalid calls: strobe 3-up, 0-down and (with FLOORS=3) 3-up -> pending stays 0, busy=0.
- Collective order: at floor 0, same-cycle-sequential strobes 3-down, 1-up, 2-down -> stops at 1 (clears up[1]); passes 2; stops at 3 (dir_up flips to 0); then DOWN to 2, stops, clears dn[2]; then IDLE.
- Absorb/extend with FLOORS=8: car dwelling at 5 going up; strobe 5-up in dwell cycle 2 -> dwell restarts, door open 5 cycles total, up_pending[5] stays 0.
